// File: rtl/song_pkg.sv
// Shared types for the song autoplayer: FSM states, tempo encodings and
// note-entry field layout ({end, rest, key, dur}, dur in the LSBs).
package song_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, SOUND, GAP} state_t;

  localparam logic [1:0] TEMPO_NORMAL = 2'd0;
  localparam logic [1:0] TEMPO_FAST   = 2'd1;
  localparam logic [1:0] TEMPO_SLOW   = 2'd2;

  function automatic int entry_w(input int key_w, input int dur_w);
    return key_w + dur_w + 2;
  endfunction

  function automatic int key_lsb(input int dur_w);
    return dur_w;
  endfunction

  function automatic int rest_bit(input int key_w, input int dur_w);
    return dur_w + key_w;
  endfunction

  function automatic int end_bit(input int key_w, input int dur_w);
    return dur_w + key_w + 1;
  endfunction

  // Index width that stays legal when only one item exists.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tempo_tick.sv
// Tick divider: one-cycle tick every N clocks, N chosen by tempo_sel and
// re-latched only at tick boundaries (or on clear).
module tempo_tick
  import song_pkg::*;
#(
  parameter int TICK_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       hold,
  input  logic [1:0] tempo_sel,
  output logic       tick
);

  localparam int CNT_W = (TICK_CYCLES * 2 > 1) ? $clog2(TICK_CYCLES * 2) : 1;
  localparam int HALF  = (TICK_CYCLES >= 2) ? TICK_CYCLES / 2 : 1;

  function automatic logic [CNT_W-1:0] limit_for(input logic [1:0] sel);
    case (sel)
      TEMPO_FAST: limit_for = CNT_W'(HALF - 1);
      TEMPO_SLOW: limit_for = CNT_W'(TICK_CYCLES * 2 - 1);
      default:    limit_for = CNT_W'(TICK_CYCLES - 1);
    endcase
  endfunction

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] limit_reg;

  assign tick = !clr && !hold && (count_reg == limit_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      limit_reg <= limit_for(TEMPO_NORMAL);
    end else if (clr) begin
      count_reg <= '0;
      limit_reg <= limit_for(tempo_sel);
    end else if (!hold) begin
      if (count_reg == limit_reg) begin
        count_reg <= '0;
        limit_reg <= limit_for(tempo_sel);
      end else begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Multi-song autoplayer: walks a note ROM (image supplied via SONG_INIT, entry 0
// in the LSBs) and drives key/key_on with tempo, rests, gaps, loop and pause.
module song_sequencer
  import song_pkg::*;
#(
  parameter int NUM_SONGS   = 4,
  parameter int MAX_NOTES   = 64,
  parameter int KEY_W       = 4,
  parameter int DUR_W       = 4,
  parameter int TICK_CYCLES = 12_500_000,
  parameter int GAP_TICKS   = 1,
  parameter logic [NUM_SONGS*MAX_NOTES*entry_w(KEY_W, DUR_W)-1:0] SONG_INIT = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           pause,
  input  logic                           loop_en,
  input  logic [sel_w(NUM_SONGS)-1:0]    song_sel,
  input  logic [1:0]                     tempo_sel,
  output logic [KEY_W-1:0]               key,
  output logic                           key_on,
  output logic                           busy,
  output logic [sel_w(MAX_NOTES)-1:0]    note_idx,
  output logic                           done
);

  localparam int ENTRY_W = entry_w(KEY_W, DUR_W);
  localparam int DEPTH   = NUM_SONGS * MAX_NOTES;
  localparam int ADDR_W  = sel_w(DEPTH);
  localparam int SONG_W  = sel_w(NUM_SONGS);
  localparam int IDX_W   = sel_w(MAX_NOTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_NOTES - 1);

  logic [ENTRY_W-1:0] rom [DEPTH];
  logic [ENTRY_W-1:0] entry_q;
  logic [ADDR_W-1:0]  rom_addr;

  state_t             state_reg;
  logic [SONG_W-1:0]  song_reg, song_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               loop_reg;
  logic [KEY_W-1:0]   key_reg;
  logic               gate_reg;
  logic               done_reg;
  logic [DUR_W-1:0]   dur_reg, ticks_reg;
  logic [DUR_W-1:0]   ticks_inc, dur_eff, on_ticks;
  logic               tick, paused, note_off, advance, wrap;

  logic               entry_end, entry_rest;
  logic [KEY_W-1:0]   entry_key;
  logic [DUR_W-1:0]   entry_dur;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
      assign rom[gi] = SONG_INIT[gi*ENTRY_W +: ENTRY_W];
    end
  endgenerate

  assign entry_end  = entry_q[end_bit(KEY_W, DUR_W)];
  assign entry_rest = entry_q[rest_bit(KEY_W, DUR_W)];
  assign entry_key  = entry_q[key_lsb(DUR_W) +: KEY_W];
  assign entry_dur  = entry_q[DUR_W-1:0];

  tempo_tick #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tempo_tick (
    .clk       (clk),
    .rst       (rst),
    .clr       (start || stop || (state_reg == FETCH)),
    .hold      (paused),
    .tempo_sel (tempo_sel),
    .tick      (tick)
  );

  always_comb begin
    paused    = pause && (state_reg != IDLE);
    dur_eff   = (dur_reg == '0) ? DUR_W'(1) : dur_reg;
    on_ticks  = (int'(dur_eff) > GAP_TICKS) ? dur_eff - DUR_W'(GAP_TICKS) : DUR_W'(1);
    ticks_inc = ticks_reg + DUR_W'(1);
    note_off  = (state_reg == SOUND) && tick && (ticks_inc == on_ticks);
    advance   = (note_off && (on_ticks == dur_eff)) ||
                ((state_reg == GAP) && tick && (ticks_inc == dur_eff));
    wrap      = ((state_reg == FETCH) && entry_end) || (advance && (idx_reg == LAST_IDX));

    // The ROM is addressed with the position being latched this cycle so the
    // entry is ready during FETCH without an extra wait state.
    song_next = song_reg;
    idx_next  = idx_reg;
    if (stop) begin
      song_next = song_reg;
    end else if (start) begin
      song_next = song_sel;
      idx_next  = '0;
    end else if (wrap) begin
      if (loop_reg) idx_next = '0;
    end else if (advance) begin
      idx_next = idx_reg + IDX_W'(1);
    end
    rom_addr = ADDR_W'(song_next) * ADDR_W'(MAX_NOTES) + ADDR_W'(idx_next);
  end

  always_ff @(posedge clk) begin
    entry_q <= rom[rom_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      song_reg  <= '0;
      idx_reg   <= '0;
      loop_reg  <= 1'b0;
      key_reg   <= '0;
      gate_reg  <= 1'b0;
      done_reg  <= 1'b0;
      dur_reg   <= '0;
      ticks_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      song_reg <= song_next;
      idx_reg  <= idx_next;
      if (stop) begin
        state_reg <= IDLE;
        gate_reg  <= 1'b0;
      end else if (start) begin
        state_reg <= FETCH;
        loop_reg  <= loop_en;
        gate_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: ;
          FETCH: begin
            if (!entry_end) begin
              state_reg <= SOUND;
              key_reg   <= entry_key;
              gate_reg  <= !entry_rest;
              dur_reg   <= entry_dur;
              ticks_reg <= '0;
            end
          end
          SOUND: begin
            if (tick) begin
              ticks_reg <= ticks_inc;
              if (note_off) begin
                gate_reg <= 1'b0;
                if (!advance) state_reg <= GAP;
              end
            end
          end
          GAP: begin
            if (tick) ticks_reg <= ticks_inc;
          end
          default: state_reg <= IDLE;
        endcase
        if (wrap) begin
          if (loop_reg) begin
            state_reg <= FETCH;
          end else begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end
        end else if (advance) begin
          state_reg <= FETCH;
        end
      end
    end
  end

  assign key      = key_reg;
  assign key_on   = gate_reg && !paused;
  assign busy     = (state_reg != IDLE);
  assign note_idx = idx_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a 4-cycle tick and two tiny songs;
// expected durations are hand-derived cycle counts observed on falling edges.
module tb_song_sequencer;

  localparam int NS = 2;
  localparam int MN = 8;

  // Entry = {end, rest, key[3:0], dur[3:0]}; entry 0 of song 0 in the LSBs.
  localparam logic [NS*MN*10-1:0] INIT = {
    10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h200, 10'h132, 10'h072,
    10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h200, 10'h051, 10'h023
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       loop_en = 1'b0;
  logic [0:0] song_sel = 1'b0;
  logic [1:0] tempo_sel = 2'd0;
  logic [3:0] key;
  logic       key_on;
  logic       busy;
  logic [2:0] note_idx;
  logic       done;

  int checks = 0;
  int failures = 0;

  song_sequencer #(
    .NUM_SONGS   (NS),
    .MAX_NOTES   (MN),
    .KEY_W       (4),
    .DUR_W       (4),
    .TICK_CYCLES (4),
    .GAP_TICKS   (1),
    .SONG_INIT   (INIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .loop_en   (loop_en),
    .song_sel  (song_sel),
    .tempo_sel (tempo_sel),
    .key       (key),
    .key_on    (key_on),
    .busy      (busy),
    .note_idx  (note_idx),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [0:0] s, input logic lp);
    song_sel = s;
    loop_en  = lp;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic run_level(input logic level, input int limit, output int n);
    n = 0;
    while (key_on === level && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check(tag, int'(busy), 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n;
    int bad;

    #1 rst = 1'b0;
    #1;
    check("reset_key", int'(key), 0);
    check("reset_key_on", int'(key_on), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_note_idx", int'(note_idx), 0);
    check("reset_done", int'(done), 0);
    cycles(2);
    rst = 1'b1;
    cycles(2);

    // 1: one-shot song 0: k2 d3 (8 on, gap+fetch 5 off), k5 d1 (4 on), end.
    pulse_start(1'b0, 1'b0);
    check("t1_fetch_busy", int'(busy), 1);
    check("t1_fetch_key_on", int'(key_on), 0);
    @(negedge clk);
    check("t1_first_key", int'(key), 2);
    run_level(1'b1, 50, n);
    check("t1_k2_on_cycles", n, 8);
    run_level(1'b0, 50, n);
    check("t1_k2_off_cycles", n, 5);
    check("t1_second_key", int'(key), 5);
    check("t1_second_idx", int'(note_idx), 1);
    run_level(1'b1, 50, n);
    check("t1_k5_on_cycles", n, 4);
    check("t1_end_fetch_idx", int'(note_idx), 2);
    check("t1_end_fetch_done", int'(done), 0);
    @(negedge clk);
    check("t1_done_pulse", int'(done), 1);
    check("t1_busy_fall", int'(busy), 0);
    check("t1_key_held", int'(key), 5);
    @(negedge clk);
    check("t1_done_one_cycle", int'(done), 0);

    // 2: loop mode: wraps to entry 0 and never pulses done over 3 passes.
    pulse_start(1'b0, 1'b1);
    cycles(18);
    check("t2_end_fetch_idx", int'(note_idx), 2);
    @(negedge clk);
    check("t2_wrap_idx", int'(note_idx), 0);
    check("t2_wrap_busy", int'(busy), 1);
    @(negedge clk);
    check("t2_replay_key", int'(key), 2);
    check("t2_replay_key_on", int'(key_on), 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done !== 1'b0) n++;
    end
    check("t2_no_done_in_loop", n, 0);
    check("t2_still_busy", int'(busy), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t2_stop_busy", int'(busy), 0);
    check("t2_stop_done", int'(done), 0);
    loop_en = 1'b0;

    // 3: tempo fast then slow, each taking effect at the next tick boundary.
    pulse_start(1'b0, 1'b0);
    @(negedge clk);
    tempo_sel = 2'd1;
    run_level(1'b1, 50, n);
    check("t3_fast_on_cycles", n, 6);
    tempo_sel = 2'd2;
    run_level(1'b0, 50, n);
    check("t3_fast_gap_cycles", n, 3);
    check("t3_second_key", int'(key), 5);
    run_level(1'b1, 50, n);
    check("t3_slow_on_cycles", n, 8);
    tempo_sel = 2'd0;
    wait_idle("t3_finish_timeout");

    // 4: pause 10 cycles in the middle of the first note.
    pulse_start(1'b0, 1'b0);
    cycles(3);
    check("t4_pre_pause_on", int'(key_on), 1);
    pause = 1'b1;
    #1;
    check("t4_pause_forces_off", int'(key_on), 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (key_on !== 1'b0 || note_idx !== 3'd0 || busy !== 1'b1) bad++;
    end
    check("t4_paused_outputs", bad, 0);
    pause = 1'b0;
    #1;
    run_level(1'b1, 50, n);
    check("t4_resume_on_cycles", n, 6);
    run_level(1'b0, 50, n);
    check("t4_resume_gap_cycles", n, 5);
    check("t4_resume_next_key", int'(key), 5);
    wait_idle("t4_finish_timeout");

    // 5: stop during GAP, then restart onto song 1 while busy.
    pulse_start(1'b0, 1'b0);
    cycles(9);
    check("t5_in_gap_key_on", int'(key_on), 0);
    check("t5_in_gap_busy", int'(busy), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t5_stop_busy", int'(busy), 0);
    check("t5_stop_key_on", int'(key_on), 0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (done !== 1'b0) n++;
      @(negedge clk);
    end
    check("t5_stop_no_done", n, 0);
    pulse_start(1'b0, 1'b0);
    cycles(2);
    pulse_start(1'b1, 1'b0);
    check("t5_restart_idx", int'(note_idx), 0);
    check("t5_restart_busy", int'(busy), 1);
    @(negedge clk);
    check("t5_song1_key", int'(key), 7);
    check("t5_song1_key_on", int'(key_on), 1);
    run_level(1'b1, 50, n);
    check("t5_k7_on_cycles", n, 4);
    run_level(1'b0, 5, n);
    check("t5_k7_off_cycles", n, 5);

    // 6: rest entry k3 d2 keeps key_on low for 8 cycles, then song ends.
    check("t6_rest_key", int'(key), 3);
    check("t6_rest_idx", int'(note_idx), 1);
    run_level(1'b0, 8, n);
    check("t6_rest_low_cycles", n, 8);
    check("t6_end_fetch_done", int'(done), 0);
    check("t6_end_fetch_busy", int'(busy), 1);
    @(negedge clk);
    check("t6_done_pulse", int'(done), 1);
    check("t6_key_held", int'(key), 3);

    // Asynchronous reset in the middle of a sounding note.
    pulse_start(1'b0, 1'b0);
    cycles(2);
    check("t6_pre_reset_on", int'(key_on), 1);
    #2 rst = 1'b0;
    #1;
    check("t6_async_key", int'(key), 0);
    check("t6_async_key_on", int'(key_on), 0);
    check("t6_async_busy", int'(busy), 0);
    check("t6_async_idx", int'(note_idx), 0);
    check("t6_async_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    check("t6_post_reset_idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
